program_sequencer: RTL and testbench

Upstream instruction source for the 16-bit processor core. It stores a short program of 9-bit words loaded from switches, then replays it onto the core's 9-bit `din` input in lock-step with the core's one-hot tick FSM. It supplies each opcode word during FETCH, and supplies the immediate word during DECODE for MOV_I. This lets the core run a program without the operator re-keying switches every instruction.

---
 rtl/seq_pkg.sv | 15 +
 rtl/program_ram.sv | 25 ++
 rtl/program_sequencer.sv | 142 ++++++++++++++
 tb/tb_program_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Definitions shared by the program sequencer and the core control unit:
// sequencer states, the MOV_I opcode and the one-hot tick phases.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } seq_state_t;

    localparam logic [2:0] OPC_MOV_I   = 3'b111;
    localparam logic [3:0] TICK_FETCH  = 4'b0001;
    localparam logic [3:0] TICK_DECODE = 4'b0010;

endpackage

// File: rtl/program_ram.sv
// DEPTH x 9 program store: one synchronous write port, one asynchronous read port.
// The array is deliberately not reset.
module program_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [8:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [8:0]    rdata
);

    logic [8:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/program_sequencer.sv
// Replays a switch-loaded program onto the core's din input, stepping in lock-step
// with the core tick FSM: opcode word at FETCH, immediate word at DECODE for MOV_I.
module program_sequencer
    import seq_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    tick,
    input  logic          load_strobe,
    input  logic [8:0]    load_data,
    input  logic          start,
    input  logic          clear,
    input  logic          loop,
    output logic [8:0]    din_out,
    output logic [AW-1:0] pc,
    output logic [AW:0]   len,
    output logic          full,
    output logic          running,
    output logic          done,
    output logic          trunc
);

    localparam logic [AW:0]   LEN_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   LEN_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PC_ONE   = AW'(1);

    seq_state_t    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW:0]   len_q, len_d;
    logic          trunc_q, trunc_d;
    logic [2:0]    opc_q, opc_d;
    logic          opc_vld_q, opc_vld_d;
    logic          we;
    logic          last;
    logic [8:0]    rdata;

    program_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (len_q[AW-1:0]),
        .wdata (load_data),
        .raddr (pc_q),
        .rdata (rdata)
    );

    assign last = ({1'b0, pc_q} + LEN_ONE) == len_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        len_d     = len_q;
        trunc_d   = trunc_q;
        opc_d     = opc_q;
        opc_vld_d = opc_vld_q;
        we        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (len_q != '0)) begin
                    state_d   = RUN;
                    pc_d      = '0;
                    trunc_d   = 1'b0;
                    opc_vld_d = 1'b0;
                end else if (clear) begin
                    len_d = '0;
                end else if (load_strobe && !full) begin
                    we    = 1'b1;
                    len_d = len_q + LEN_ONE;
                end
            end
            RUN: begin
                // A restart wins over any tick in the same cycle.
                if (start) begin
                    pc_d      = '0;
                    trunc_d   = 1'b0;
                    opc_vld_d = 1'b0;
                end else if (tick == TICK_FETCH) begin
                    opc_d     = rdata[8:6];
                    opc_vld_d = 1'b1;
                    if (!last) begin
                        pc_d = pc_q + PC_ONE;
                    end else if (loop) begin
                        pc_d = '0;
                    end else begin
                        state_d = HALT;
                        trunc_d = (rdata[8:6] == OPC_MOV_I);
                    end
                end else if ((tick == TICK_DECODE) && opc_vld_q && (opc_q == OPC_MOV_I)) begin
                    opc_vld_d = 1'b0;
                    if (!last) begin
                        pc_d = pc_q + PC_ONE;
                    end else if (loop) begin
                        pc_d = '0;
                    end else begin
                        state_d = HALT;
                    end
                end
            end
            HALT: begin
                if (start) begin
                    state_d   = RUN;
                    pc_d      = '0;
                    trunc_d   = 1'b0;
                    opc_vld_d = 1'b0;
                end else if (clear) begin
                    state_d = IDLE;
                    len_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            len_q     <= '0;
            trunc_q   <= 1'b0;
            opc_q     <= '0;
            opc_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            len_q     <= len_d;
            trunc_q   <= trunc_d;
            opc_q     <= opc_d;
            opc_vld_q <= opc_vld_d;
        end
    end

    assign din_out = (state_q == RUN) ? rdata : 9'h000;
    assign pc      = pc_q;
    assign len     = len_q;
    assign full    = (len_q == LEN_FULL);
    assign running = (state_q == RUN);
    assign done    = (state_q == HALT);
    assign trunc   = trunc_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: load, replay, loop, full, truncation,
// async reset and start/clear priority, with hand-computed expectations.
module tb_program_sequencer;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [3:0] T_F = 4'b0001;
    localparam logic [3:0] T_D = 4'b0010;
    localparam logic [3:0] T_3 = 4'b0100;
    localparam logic [3:0] T_4 = 4'b1000;

    logic          clk;
    logic          rst_n;
    logic [3:0]    tick;
    logic          load_strobe;
    logic [8:0]    load_data;
    logic          start;
    logic          clear;
    logic          loop;
    logic [8:0]    din_out;
    logic [AW-1:0] pc;
    logic [AW:0]   len;
    logic          full;
    logic          running;
    logic          done;
    logic          trunc;

    int tests_run;
    int tests_failed;

    program_sequencer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .load_strobe (load_strobe),
        .load_data   (load_data),
        .start       (start),
        .clear       (clear),
        .loop        (loop),
        .din_out     (din_out),
        .pc          (pc),
        .len         (len),
        .full        (full),
        .running     (running),
        .done        (done),
        .trunc       (trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one active edge and settle just after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic load_word(input logic [8:0] w);
        load_strobe = 1'b1;
        load_data   = w;
        cyc();
        load_strobe = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        tick         = 4'b0000;
        load_strobe  = 1'b0;
        load_data    = '0;
        start        = 1'b0;
        clear        = 1'b0;
        loop         = 1'b0;
        do_reset();

        // Reset state
        chk("rst_pc", 32'(pc), 0);
        chk("rst_len", 32'(len), 0);
        chk("rst_running", 32'(running), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_trunc", 32'(trunc), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_din", 32'(din_out), 0);

        // MOV_I R0 #5 ; DISP R0 ; halt at program end
        load_word(9'o700);
        load_word(9'h005);
        load_word(9'o000);
        chk("p1_len", 32'(len), 3);
        chk("p1_idle_din", 32'(din_out), 0);
        pulse_start();
        chk("p1_running", 32'(running), 1);
        chk("p1_start_pc", 32'(pc), 0);
        tick = T_F;
        chk("p1_fetch1_din", 32'(din_out), 32'o700);
        cyc();
        tick = T_D;
        chk("p1_decode1_din", 32'(din_out), 32'h005);
        cyc();
        tick = T_3; cyc();
        tick = T_4; cyc();
        tick = T_F;
        chk("p1_fetch2_din", 32'(din_out), 32'o000);
        chk("p1_fetch2_pc", 32'(pc), 2);
        cyc();
        chk("p1_done", 32'(done), 1);
        chk("p1_halt_running", 32'(running), 0);
        chk("p1_halt_pc", 32'(pc), 2);
        chk("p1_halt_din", 32'(din_out), 0);
        chk("p1_trunc", 32'(trunc), 0);
        tick = T_D; cyc();
        tick = T_3; cyc();
        tick = T_4; cyc();
        tick = T_F; cyc();
        chk("p1_halt_pc_held", 32'(pc), 2);
        chk("p1_halt_done_held", 32'(done), 1);

        // start and clear together in HALT: start wins
        tick  = 4'b0000;
        start = 1'b1;
        clear = 1'b1;
        cyc();
        start = 1'b0;
        clear = 1'b0;
        chk("sc_running", 32'(running), 1);
        chk("sc_pc", 32'(pc), 0);
        chk("sc_len", 32'(len), 3);
        // Run through to HALT again, then clear to IDLE
        tick = T_F; cyc();
        tick = T_D; cyc();
        tick = T_F; cyc();
        chk("sc_done_again", 32'(done), 1);
        tick  = 4'b0000;
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("clr_len", 32'(len), 0);
        chk("clr_done", 32'(done), 0);
        chk("clr_running", 32'(running), 0);
        // start with empty program is ignored
        pulse_start();
        chk("empty_start_running", 32'(running), 0);
        chk("empty_start_done", 32'(done), 0);

        // Looping two-word program
        do_reset();
        loop = 1'b1;
        load_word(9'o100);
        load_word(9'o000);
        pulse_start();
        tick = T_F;
        chk("loop_f1_din", 32'(din_out), 32'o100);
        cyc();
        tick = T_D; cyc();
        chk("loop_nomovi_pc", 32'(pc), 1);
        tick = T_3; cyc();
        tick = T_4; cyc();
        tick = T_F;
        chk("loop_f2_din", 32'(din_out), 32'o000);
        cyc();
        chk("loop_wrap_pc", 32'(pc), 0);
        tick = T_D; cyc();
        tick = T_3; cyc();
        tick = T_4; cyc();
        tick = T_F;
        chk("loop_f3_din", 32'(din_out), 32'o100);
        cyc();
        chk("loop_done", 32'(done), 0);
        chk("loop_running", 32'(running), 1);
        loop = 1'b0;

        // Fill to DEPTH, then an extra strobe is ignored
        do_reset();
        tick = 4'b0000;
        for (int i = 0; i < DEPTH; i++) begin
            load_word(9'(i * 3 + 1));
        end
        chk("full_flag", 32'(full), 1);
        chk("full_len", 32'(len), DEPTH);
        load_word(9'h1FF);
        chk("full_len_after_extra", 32'(len), DEPTH);
        pulse_start();
        for (int i = 0; i < DEPTH - 1; i++) begin
            tick = T_F;
            chk("full_word", 32'(din_out), 32'(i * 3 + 1));
            cyc();
        end
        tick = 4'b0000;
        chk("full_pc15", 32'(pc), 15);
        chk("full_word15", 32'(din_out), 46);

        // Lone MOV_I: truncated immediate
        do_reset();
        load_word(9'o700);
        pulse_start();
        tick = T_F;
        chk("tr_fetch_din", 32'(din_out), 32'o700);
        cyc();
        chk("tr_done", 32'(done), 1);
        chk("tr_trunc", 32'(trunc), 1);
        chk("tr_pc", 32'(pc), 0);
        tick = T_D;
        chk("tr_decode_din", 32'(din_out), 0);
        cyc();
        chk("tr_trunc_sticky", 32'(trunc), 1);
        // restart clears trunc
        tick = 4'b0000;
        pulse_start();
        chk("tr_restart_trunc", 32'(trunc), 0);

        // Asynchronous reset in the middle of RUN at DECODE
        do_reset();
        load_word(9'o700);
        load_word(9'h005);
        load_word(9'o000);
        pulse_start();
        tick = T_F; cyc();
        tick = T_D;
        chk("ar_pre_din", 32'(din_out), 32'h005);
        chk("ar_pre_running", 32'(running), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_din", 32'(din_out), 0);
        chk("ar_pc", 32'(pc), 0);
        chk("ar_len", 32'(len), 0);
        chk("ar_running", 32'(running), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick  = 4'b0000;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
